east_merge_arbiter: RTL and testbench
=====================================

Name: east_merge_arbiter

Overview:
- Eastward merge/turn stage of a router node.
- Arbitrates between two packet sources: the core's east-bound injection buffer (local) and the buffer holding packets received from the west neighbour (link).
- Each head packet is steered by its signed dx field: dx>0 goes out the east port with dx decremented; dx==0 turns toward the vertical (dy) stage.
- Downstream buffers are protected by per-output credit counters, so writes are fully registered without overflow races.

Parameters:
PACKET_WIDTH, 30, packet width in bits
DX_MSB, 29, MSB of signed dx field
DX_LSB, 21, LSB of signed dx field
CREDITS, 4, depth of each downstream buffer; initial credit count per output

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous and active-low
local_dout  input  PACKET_WIDTH  head packet of local east-bound buffer
local_empty  input  1  local buffer empty
local_ren  output  1  pop local buffer (combinational)
link_dout  input  PACKET_WIDTH  head packet of west-link buffer
link_empty  input  1  west-link buffer empty
link_ren  output  1  pop west-link buffer (combinational)
dout_east  output  PACKET_WIDTH  packet to east neighbour, dx already decremented
wen_east  output  1  write strobe to east neighbour buffer
credit_east  input  1  east downstream buffer popped one entry
dout_turn  output  PACKET_WIDTH  packet to vertical stage, unmodified
wen_turn  output  1  write strobe to vertical stage buffer
credit_turn  input  1  vertical stage buffer popped one entry
err  output  1  sticky: a packet with dx<0 was received

Behaviour:
- Head decode per source, valid only when its empty==0:
  - dx==0 requests turn.
  - dx>0 requests east.
  - dx<0 is a bad packet.
- Bad packet:
  - The source is popped (ren=1) unconditionally that cycle; it needs no credit and no arbitration.
  - err is set next cycle and held until reset.
  - Nothing is written to either output.
- Each output (east, turn) has an independent round-robin pointer and a credit counter of width clog2(CREDITS+1).
- Grant for an output is issued only when credits>0 and at least one source requests it.
  - Both sources requesting: grant the pointer's favoured source; the pointer then moves to the other source.
  - One source requesting: grant it; pointer unchanged.
- Both sources may be granted in the same cycle if they target different outputs.
- A source is granted at most one output per cycle.
- ren for the granted source is asserted combinationally in the grant cycle.
- Output register loads at the clock edge ending the grant cycle:
  - dout_x and wen_x are valid exactly 1 cycle after the grant, latency 1.
  - wen_x is a single-cycle pulse per packet.
  - Back-to-back grants give wen_x high on consecutive cycles (full throughput of 1 packet/cycle/output).
- East path: dx field replaced by dx-1, computed at field width; all other bits pass unchanged. The dx>0 precondition makes underflow impossible. Turn path passes the packet unchanged.
- Credit counter update:
  - Grant only: -1.
  - credit_x only: +1.
  - Both in the same cycle: unchanged.
  - credit_x while the counter is already at CREDITS (and no grant): ignored, counter saturates.
  - Counter at 0: no grant to that output; requesters stall with ren=0 and their head packets are held.
- Head-of-line: a source whose head packet is stalled blocks that source only; the other source continues to be served.
- When wen_x=0, dout_x holds its last value (don't-care for downstream).
- Reset (rst=0 at clk edge):
  - wen_east=wen_turn=0, dout_east=dout_turn=0, err=0.
  - Both credit counters=CREDITS.
  - Both pointers favour link (through traffic first).
  - Reset mid-operation discards any in-flight registered write.
  - While rst=0: local_ren and link_ren are forced 0.

Test Plan:
- Reset, then local head dx=3 (other fields 0x0ABC), link empty -> local_ren=1 in cycle 0; cycle 1: wen_east=1, dout_east dx=2, low bits 0x0ABC; east credits 4->3.
- Both sources dx=1, continuously non-empty, no credit returns -> grants alternate link, local, link, local; wen_east high 4 consecutive cycles; 5th request stalls with ren=0 until credit_east pulses, then one grant the following cycle.
- local dx=0, link dx=5 in the same cycle -> both ren=1; next cycle wen_turn=1 with dout_turn equal to local_dout unchanged, and wen_east=1 with dx=4.
- Grant to east and credit_east in the same cycle with credits=2 -> credits stay 2; credit_east with credits=4 and no grant -> stays 4.
- link head dx=-1 -> link_ren=1, no wen on either output, err=1 next cycle and stays 1 through further traffic until rst=0.
- Assert rst=0 during a burst with credits=1 -> next cycle wen_east/wen_turn=0, credits=4, err=0, rens=0 while reset is held; first post-reset conflict is granted to link.

Source files
------------

// File: rtl/east_merge_arbiter.sv
// Eastward merge/turn stage: arbitrates the local injection buffer and the
// west-link buffer onto the east output and the vertical-turn output.
module east_merge_arbiter #(
  parameter int PACKET_WIDTH = 30,
  parameter int DX_MSB       = 29,
  parameter int DX_LSB       = 21,
  parameter int CREDITS      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] local_dout,
  input  logic                    local_empty,
  output logic                    local_ren,
  input  logic [PACKET_WIDTH-1:0] link_dout,
  input  logic                    link_empty,
  output logic                    link_ren,
  output logic [PACKET_WIDTH-1:0] dout_east,
  output logic                    wen_east,
  input  logic                    credit_east,
  output logic [PACKET_WIDTH-1:0] dout_turn,
  output logic                    wen_turn,
  input  logic                    credit_turn,
  output logic                    err
);

  localparam int DXW = DX_MSB - DX_LSB + 1;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0]           r_cred_east, r_cred_turn;
  logic                    r_ptr_east, r_ptr_turn;
  logic [PACKET_WIDTH-1:0] r_dout_east, r_dout_turn;
  logic                    r_wen_east, r_wen_turn, r_err;

  logic [DXW-1:0]          w_loc_dx, w_lnk_dx;
  logic                    w_loc_bad, w_loc_turn, w_loc_east;
  logic                    w_lnk_bad, w_lnk_turn, w_lnk_east;
  logic [1:0]              w_ge, w_gt;
  logic                    w_ge_any, w_gt_any, w_ge_conf, w_gt_conf;
  logic [PACKET_WIDTH-1:0] w_east_src, w_east_pkt, w_turn_pkt;

  // Grant vector {local, link}; ptr_loc=1 favours local on a conflict.
  function automatic logic [1:0] arb(input logic req_lnk, input logic req_loc,
                                     input logic ptr_loc, input logic has_cred);
    logic [1:0] g;
    g = '0;
    if (has_cred) begin
      if (req_lnk && req_loc) g = ptr_loc ? 2'b10 : 2'b01;
      else                    g = {req_loc, req_lnk};
    end
    return g;
  endfunction

  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c,
                                              input logic take, input logic give);
    logic [CW-1:0] n;
    n = c;
    if (take && !give)                   n = c - CW'(1);
    else if (give && !take && c != CMAX) n = c + CW'(1);
    return n;
  endfunction

  always_comb begin
    w_loc_dx   = local_dout[DX_MSB:DX_LSB];
    w_lnk_dx   = link_dout[DX_MSB:DX_LSB];
    w_loc_bad  = !local_empty && w_loc_dx[DXW-1];
    w_loc_turn = !local_empty && (w_loc_dx == '0);
    w_loc_east = !local_empty && !w_loc_dx[DXW-1] && (w_loc_dx != '0);
    w_lnk_bad  = !link_empty && w_lnk_dx[DXW-1];
    w_lnk_turn = !link_empty && (w_lnk_dx == '0);
    w_lnk_east = !link_empty && !w_lnk_dx[DXW-1] && (w_lnk_dx != '0);

    // Each source requests exactly one output, so it can win at most one grant.
    w_ge      = arb(w_lnk_east, w_loc_east, r_ptr_east, r_cred_east != '0);
    w_gt      = arb(w_lnk_turn, w_loc_turn, r_ptr_turn, r_cred_turn != '0);
    w_ge_any  = |w_ge;
    w_gt_any  = |w_gt;
    w_ge_conf = w_lnk_east && w_loc_east && (r_cred_east != '0);
    w_gt_conf = w_lnk_turn && w_loc_turn && (r_cred_turn != '0);

    w_east_src = w_ge[1] ? local_dout : link_dout;
    w_east_pkt = w_east_src;
    w_east_pkt[DX_MSB:DX_LSB] = w_east_src[DX_MSB:DX_LSB] - DXW'(1);
    w_turn_pkt = w_gt[1] ? local_dout : link_dout;

    local_ren = rst && (w_loc_bad || w_ge[1] || w_gt[1]);
    link_ren  = rst && (w_lnk_bad || w_ge[0] || w_gt[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cred_east <= CMAX;
      r_cred_turn <= CMAX;
      r_ptr_east  <= 1'b0;
      r_ptr_turn  <= 1'b0;
      r_dout_east <= '0;
      r_dout_turn <= '0;
      r_wen_east  <= 1'b0;
      r_wen_turn  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cred_east <= cred_next(r_cred_east, w_ge_any, credit_east);
      r_cred_turn <= cred_next(r_cred_turn, w_gt_any, credit_turn);
      if (w_ge_conf) r_ptr_east <= ~r_ptr_east;
      if (w_gt_conf) r_ptr_turn <= ~r_ptr_turn;
      r_wen_east <= w_ge_any;
      r_wen_turn <= w_gt_any;
      if (w_ge_any) r_dout_east <= w_east_pkt;
      if (w_gt_any) r_dout_turn <= w_turn_pkt;
      if (w_loc_bad || w_lnk_bad) r_err <= 1'b1;
    end
  end

  assign dout_east = r_dout_east;
  assign wen_east  = r_wen_east;
  assign dout_turn = r_dout_turn;
  assign wen_turn  = r_wen_turn;
  assign err       = r_err;

endmodule

// File: tb/tb_east_merge_arbiter.sv
// Directed bench for east_merge_arbiter; expected writes go into per-output
// scoreboards tagged with the cycle they must appear in.
module tb_east_merge_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] local_dout = '0, link_dout = '0;
  logic        local_empty = 1'b1, link_empty = 1'b1;
  logic        local_ren, link_ren;
  logic [29:0] dout_east, dout_turn;
  logic        wen_east, wen_turn;
  logic        credit_east = 1'b0, credit_turn = 1'b0;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int due; logic [29:0] p; } exp_t;
  exp_t qe[$];
  exp_t qt[$];

  localparam logic [29:0] Z = '0;

  east_merge_arbiter #(.PACKET_WIDTH(30), .DX_MSB(29), .DX_LSB(21), .CREDITS(4)) dut (
    .clk(clk), .rst(rst),
    .local_dout(local_dout), .local_empty(local_empty), .local_ren(local_ren),
    .link_dout(link_dout), .link_empty(link_empty), .link_ren(link_ren),
    .dout_east(dout_east), .wen_east(wen_east), .credit_east(credit_east),
    .dout_turn(dout_turn), .wen_turn(wen_turn), .credit_turn(credit_turn),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] pk(input int dx, input logic [20:0] lo);
    logic [8:0] d;
    d = dx[8:0];
    return {d, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational pops, queue expected writes.
  task automatic step(input bit r,
                      input bit le, input logic [29:0] ld,
                      input bit ke, input logic [29:0] kd,
                      input bit ce, input bit ct,
                      input bit xl, input bit xk,
                      input bit pe, input logic [29:0] ee,
                      input bit pt, input logic [29:0] et);
    exp_t e;
    @(posedge clk); #1;
    rst = r; local_empty = le; local_dout = ld; link_empty = ke; link_dout = kd;
    credit_east = ce; credit_turn = ct;
    if (pe) begin e.due = cyc + 1; e.p = ee; qe.push_back(e); end
    if (pt) begin e.due = cyc + 1; e.p = et; qt.push_back(e); end
    @(negedge clk);
    chk("local_ren", {31'd0, local_ren}, {31'd0, xl});
    chk("link_ren",  {31'd0, link_ren},  {31'd0, xk});
  endtask

  // Monitor: every write strobe must match the head of its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (wen_east === 1'b1) begin
      if (qe.size() == 0) begin
        total++; bad++;
        $display("FAIL east_unexpected cycle=%0d got=%h expected=none", cyc, dout_east);
      end else begin
        e = qe.pop_front();
        chk("east_cycle", e.due, cyc);
        chk("east_data", {2'b0, dout_east}, {2'b0, e.p});
      end
    end
    if (wen_turn === 1'b1) begin
      if (qt.size() == 0) begin
        total++; bad++;
        $display("FAIL turn_unexpected cycle=%0d got=%h expected=none", cyc, dout_turn);
      end else begin
        e = qt.pop_front();
        chk("turn_cycle", e.due, cyc);
        chk("turn_data", {2'b0, dout_turn}, {2'b0, e.p});
      end
    end
  end

  initial begin
    // Reset with both sources non-empty: pops must stay low.
    step(0, 0,pk(1,21'h1), 0,pk(1,21'h2), 0,0, 0,0, 0,Z, 0,Z);
    step(0, 0,pk(1,21'h1), 0,pk(1,21'h2), 0,0, 0,0, 0,Z, 0,Z);
    chk("rst_wen_east", {31'd0, wen_east}, 32'd0);
    chk("rst_wen_turn", {31'd0, wen_turn}, 32'd0);
    chk("rst_dout_east", {2'b0, dout_east}, 32'd0);
    chk("rst_dout_turn", {2'b0, dout_turn}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Single local east packet, dx 3 -> 2.
    step(1, 0,pk(3,21'h0ABC), 1,Z, 0,0, 1,0, 1,pk(2,21'h0ABC), 0,Z);
    step(1, 1,Z, 1,Z, 1,0, 0,0, 0,Z, 0,Z);   // east credits 3 -> 4
    step(1, 1,Z, 1,Z, 1,0, 0,0, 0,Z, 0,Z);   // saturates at 4

    // Conflict round robin: link, local, link, local, then stall.
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 0,1, 1,pk(0,21'h222), 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 1,0, 1,pk(0,21'h111), 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 0,1, 1,pk(0,21'h222), 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 1,0, 1,pk(0,21'h111), 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 0,0, 0,Z, 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 1,0, 0,0, 0,Z, 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 0,1, 1,pk(0,21'h222), 0,Z);
    step(1, 0,pk(1,21'h111), 0,pk(1,21'h222), 0,0, 0,0, 0,Z, 0,Z);
    for (int i = 0; i < 4; i++) step(1, 1,Z, 1,Z, 1,0, 0,0, 0,Z, 0,Z);

    // Local turns while link goes east in the same cycle.
    step(1, 0,pk(0,21'h333), 0,pk(5,21'h444), 0,0, 1,1, 1,pk(4,21'h444), 1,pk(0,21'h333));

    // East credits 3 -> 2, then grant+credit keeps 2: two more grants, then stall.
    step(1, 1,Z, 0,pk(2,21'h555), 0,0, 0,1, 1,pk(1,21'h555), 0,Z);
    step(1, 1,Z, 0,pk(2,21'h666), 1,0, 0,1, 1,pk(1,21'h666), 0,Z);
    step(1, 1,Z, 0,pk(2,21'h777), 0,0, 0,1, 1,pk(1,21'h777), 0,Z);
    step(1, 1,Z, 0,pk(2,21'h999), 0,0, 0,1, 1,pk(1,21'h999), 0,Z);
    step(1, 1,Z, 0,pk(2,21'hAAA), 0,0, 0,0, 0,Z, 0,Z);

    // Bad packet: popped with no credit, err the cycle after, sticky.
    step(1, 1,Z, 0,pk(-1,21'h0F0), 0,0, 0,1, 0,Z, 0,Z);
    chk("err_before", {31'd0, err}, 32'd0);
    step(1, 0,pk(0,21'hBBB), 1,Z, 0,0, 1,0, 0,Z, 1,pk(0,21'hBBB));
    chk("err_set", {31'd0, err}, 32'd1);
    step(1, 1,Z, 1,Z, 0,0, 0,0, 0,Z, 0,Z);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Turn credits 2 -> 1 with a grant, then reset lands during the burst.
    step(1, 0,pk(0,21'hC01), 1,Z, 0,0, 1,0, 0,Z, 1,pk(0,21'hC01));
    step(0, 0,pk(0,21'hC02), 0,pk(1,21'hD01), 0,0, 0,0, 0,Z, 0,Z);
    step(0, 0,pk(0,21'hC02), 0,pk(1,21'hD01), 0,0, 0,0, 0,Z, 0,Z);
    chk("rst2_wen_east", {31'd0, wen_east}, 32'd0);
    chk("rst2_wen_turn", {31'd0, wen_turn}, 32'd0);
    chk("rst2_dout_east", {2'b0, dout_east}, 32'd0);
    chk("rst2_dout_turn", {2'b0, dout_turn}, 32'd0);
    chk("rst2_err", {31'd0, err}, 32'd0);

    // After reset: east credits restored, conflict goes to link first.
    step(1, 0,pk(1,21'hE01), 0,pk(1,21'hE02), 0,0, 0,1, 1,pk(0,21'hE02), 0,Z);
    step(1, 0,pk(1,21'hE01), 1,Z, 0,0, 1,0, 1,pk(0,21'hE01), 0,Z);
    for (int i = 0; i < 3; i++) step(1, 1,Z, 1,Z, 0,0, 0,0, 0,Z, 0,Z);

    chk("east_drained", qe.size(), 32'd0);
    chk("turn_drained", qt.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
